fp_alu_issue: RTL and testbench

- Upstream issue stage for the single-precision FP ALU (add/sub/div/mul, 2-bit opcode).
- Accepts operations with A, B, opcode and tag over a valid/ready handshake, and buffers them in an operand FIFO.
- Drives the ALU at most one op per cycle, tracks each op through the ALU's fixed latency with a valid/tag pipe, and captures results into a result queue.
- The result queue presents results in order downstream with valid/ready backpressure. Results are never dropped.

---
 rtl/fp_alu_pkg.sv | 34 +++
 rtl/fp_sync_fifo.sv | 46 ++++
 rtl/fp_alu_issue.sv | 146 ++++++++++++++
 tb/tb_fp_alu_issue.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_alu_pkg.sv
// Shared opcode, IEEE-754 field constants and result-flag type for the FP ALU issue stage.
package fp_alu_pkg;

  typedef enum logic [1:0] {
    OP_ADD = 2'b00,
    OP_SUB = 2'b01,
    OP_DIV = 2'b10,
    OP_MUL = 2'b11
  } fp_op_e;

  localparam int unsigned EXP_MSB     = 30;
  localparam int unsigned EXP_LSB     = 23;
  localparam int unsigned MAN_MSB     = 22;
  localparam logic [7:0]  EXP_SPECIAL = 8'hFF;
  localparam int unsigned FLAGS_W     = 3;

  typedef struct packed {
    logic nan;
    logic inf;
    logic zero;
  } fp_flags_t;

  // Classify a single-precision value; denormals are neither zero nor special.
  function automatic fp_flags_t fp_classify(input logic [31:0] v);
    fp_flags_t f;
    logic      man_nz;
    man_nz = |v[MAN_MSB:0];
    f.nan  = (v[EXP_MSB:EXP_LSB] == EXP_SPECIAL) && man_nz;
    f.inf  = (v[EXP_MSB:EXP_LSB] == EXP_SPECIAL) && !man_nz;
    f.zero = (v[EXP_MSB:EXP_LSB] == 8'h00) && !man_nz;
    return f;
  endfunction

endpackage

// File: rtl/fp_sync_fifo.sv
// Single-clock FIFO with occupancy counter; head entry is always visible on rdata.
module fp_sync_fifo
  import fp_alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem[rd_ptr];
  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);

endmodule

// File: rtl/fp_alu_issue.sv
// Issue stage for the FP ALU: operand FIFO, credit-gated issue, latency-tracking tag pipe, result queue.
// Optional per-result {nan, inf, zero} flags are enabled by defining FP_ALU_ISSUE_FLAGS_EN.
module fp_alu_issue #(
  parameter int unsigned IQ_DEPTH = 4,
  parameter int unsigned RQ_DEPTH = 4,
  parameter int unsigned ALU_LAT  = 2,
  parameter int unsigned TAG_W    = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [1:0]       in_op,
  input  logic [TAG_W-1:0] in_tag,
  output logic [31:0]      alu_a,
  output logic [31:0]      alu_b,
  output logic [1:0]       alu_op,
  input  logic [31:0]      alu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic [TAG_W-1:0] out_tag
`ifdef FP_ALU_ISSUE_FLAGS_EN
  ,
  output logic [2:0]       out_flags
`endif
);

  import fp_alu_pkg::*;

  localparam int unsigned IQ_W   = 66 + TAG_W;
`ifdef FP_ALU_ISSUE_FLAGS_EN
  localparam int unsigned RQ_W   = 32 + TAG_W + FLAGS_W;
`else
  localparam int unsigned RQ_W   = 32 + TAG_W;
`endif
  localparam int unsigned IQ_CW  = $clog2(IQ_DEPTH) + 1;
  localparam int unsigned RQ_CW  = $clog2(RQ_DEPTH) + 1;
  localparam int unsigned CRED_W = $clog2(RQ_DEPTH + 1);

  logic [IQ_W-1:0]   iq_rdata;
  logic              iq_full, iq_empty, iq_push;
  logic [IQ_CW-1:0]  iq_count;
  logic [RQ_W-1:0]   rq_wdata, rq_rdata;
  logic              rq_full, rq_empty, rq_push, rq_pop;
  logic [RQ_CW-1:0]  rq_count;
  logic [CRED_W-1:0] credits;
  logic              issue;

  logic              iss_vld;
  logic [TAG_W-1:0]  iss_tag;
  logic [ALU_LAT-1:0] pipe_vld;
  logic [TAG_W-1:0]  pipe_tag [ALU_LAT];

  assign in_ready = !iq_full;
  assign iq_push  = in_valid && in_ready;
  assign issue    = !iq_empty && (credits != '0);

  fp_sync_fifo #(.WIDTH(IQ_W), .DEPTH(IQ_DEPTH)) u_iq (
    .clk   (clk),
    .rst   (rst),
    .push  (iq_push),
    .wdata ({in_a, in_b, in_op, in_tag}),
    .pop   (issue),
    .rdata (iq_rdata),
    .full  (iq_full),
    .empty (iq_empty),
    .count (iq_count)
  );

  // alu_o trails the alu_* registers by ALU_LAT edges, so the tag pipe starts alongside them.
  always_ff @(posedge clk) begin
    if (rst) begin
      alu_a    <= '0;
      alu_b    <= '0;
      alu_op   <= '0;
      iss_vld  <= 1'b0;
      iss_tag  <= '0;
      pipe_vld <= '0;
      for (int i = 0; i < int'(ALU_LAT); i++) pipe_tag[i] <= '0;
    end else begin
      iss_vld <= issue;
      if (issue) begin
        alu_a   <= iq_rdata[IQ_W-1 -: 32];
        alu_b   <= iq_rdata[IQ_W-33 -: 32];
        alu_op  <= iq_rdata[TAG_W +: 2];
        iss_tag <= iq_rdata[TAG_W-1:0];
      end
      pipe_vld[0] <= iss_vld;
      pipe_tag[0] <= iss_tag;
      for (int i = 1; i < int'(ALU_LAT); i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        pipe_tag[i] <= pipe_tag[i-1];
      end
    end
  end

  // Credits reserve a result slot at issue and return it when the consumer pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      credits <= CRED_W'(RQ_DEPTH);
    end else if (issue && !rq_pop) begin
      credits <= credits - CRED_W'(1);
    end else if (!issue && rq_pop) begin
      credits <= credits + CRED_W'(1);
    end
  end

  assign rq_push = pipe_vld[ALU_LAT-1];
  assign rq_pop  = out_valid && out_ready;

`ifdef FP_ALU_ISSUE_FLAGS_EN
  assign rq_wdata = {alu_o, pipe_tag[ALU_LAT-1], fp_classify(alu_o)};
`else
  assign rq_wdata = {alu_o, pipe_tag[ALU_LAT-1]};
`endif

  fp_sync_fifo #(.WIDTH(RQ_W), .DEPTH(RQ_DEPTH)) u_rq (
    .clk   (clk),
    .rst   (rst),
    .push  (rq_push),
    .wdata (rq_wdata),
    .pop   (rq_pop),
    .rdata (rq_rdata),
    .full  (rq_full),
    .empty (rq_empty),
    .count (rq_count)
  );

  assign out_valid = !rq_empty;
  assign out_data  = rq_rdata[RQ_W-1 -: 32];
  assign out_tag   = rq_rdata[RQ_W-33 -: TAG_W];
`ifdef FP_ALU_ISSUE_FLAGS_EN
  assign out_flags = rq_rdata[FLAGS_W-1:0];
`endif

  a_credit_bound: assert property (@(posedge clk) disable iff (rst)
    (32'(rq_count) + 32'(credits)) <= RQ_DEPTH);
  a_rq_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(rq_push && rq_full));
  a_iq_count: assert property (@(posedge clk) disable iff (rst)
    iq_empty == (iq_count == '0));

endmodule

// File: tb/tb_fp_alu_issue.sv
// Randomized self-checking bench for fp_alu_issue against a queue-based reference model.
module tb_fp_alu_issue;

  localparam int unsigned IQ_DEPTH = 4;
  localparam int unsigned RQ_DEPTH = 4;
  localparam int unsigned ALU_LAT  = 2;
  localparam int unsigned TAG_W    = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid, in_ready;
  logic [31:0]      in_a, in_b;
  logic [1:0]       in_op;
  logic [TAG_W-1:0] in_tag;
  logic [31:0]      alu_a, alu_b, alu_o;
  logic [1:0]       alu_op;
  logic             out_valid, out_ready;
  logic [31:0]      out_data;
  logic [TAG_W-1:0] out_tag;
`ifdef FP_ALU_ISSUE_FLAGS_EN
  logic [2:0]       out_flags;
`endif

  fp_alu_issue #(.IQ_DEPTH(IQ_DEPTH), .RQ_DEPTH(RQ_DEPTH), .ALU_LAT(ALU_LAT), .TAG_W(TAG_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_op     (in_op),
    .in_tag    (in_tag),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_o     (alu_o),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_tag   (out_tag)
`ifdef FP_ALU_ISSUE_FLAGS_EN
    ,
    .out_flags (out_flags)
`endif
  );

  always #5 clk = ~clk;

  // Single <-> double conversions for normals, zero, inf and NaN (denormals flush to zero).
  function automatic logic [63:0] s2d(input logic [31:0] s);
    if (s[30:23] == 8'h00) return {s[31], 63'd0};
    if (s[30:23] == 8'hFF) return {s[31], 11'h7FF, s[22:0], 29'd0};
    return {s[31], 11'(s[30:23]) + 11'd896, s[22:0], 29'd0};
  endfunction

  function automatic logic [31:0] d2s(input logic [63:0] d);
    int ex;
    ex = int'(d[62:52]) - 896;
    if (d[62:52] == 11'd0) return {d[63], 31'd0};
    if (d[62:52] == 11'h7FF) return {d[63], 8'hFF, d[51:29]};
    if (ex >= 255) return {d[63], 8'hFF, 23'd0};
    if (ex <= 0) return {d[63], 31'd0};
    return {d[63], 8'(ex), d[51:29]};
  endfunction

  function automatic logic [31:0] fp_model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
    real ra, rb, r;
    if ((a[30:23] == 8'hFF && a[22:0] != 0) || (b[30:23] == 8'hFF && b[22:0] != 0)) return 32'h7FC00000;
    ra = $bitstoreal(s2d(a));
    rb = $bitstoreal(s2d(b));
    case (op)
      2'b00:   r = ra + rb;
      2'b01:   r = ra - rb;
      2'b10:   r = ra / rb;
      default: r = ra * rb;
    endcase
    return d2s($realtobits(r));
  endfunction

  function automatic logic [2:0] exp_flags(input logic [31:0] v);
    logic [2:0] f;
    f[2] = (v[30:23] == 8'hFF) && (v[22:0] != 0);
    f[1] = (v[30:23] == 8'hFF) && (v[22:0] == 0);
    f[0] = (v[30:0] == 31'd0);
    return f;
  endfunction

  // Model ALU: ALU_LAT register stages behind alu_a/alu_b/alu_op.
  logic [31:0] apipe [ALU_LAT];
  always @(posedge clk) begin
    apipe[0] <= fp_model(alu_a, alu_b, alu_op);
    for (int i = 1; i < int'(ALU_LAT); i++) apipe[i] <= apipe[i-1];
  end
  assign alu_o = apipe[ALU_LAT-1];

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
  } exp_t;

  typedef struct {
    logic [31:0]      d;
    logic [TAG_W-1:0] t;
    logic [2:0]       f;
    int               cyc;
  } pop_t;

  exp_t        exp_q [$];
  pop_t        pop_log [$];
  int          n_checks = 0;
  int          n_err    = 0;
  int          n_acc    = 0;
  int          n_pop    = 0;
  int          cyc      = 0;
  logic [31:0] pool [8];
  logic [31:0] divs [4];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Account for handshakes that the coming edge will complete, then advance one cycle.
  task automatic step();
    exp_t e;
    pop_t p;
    if (in_valid && in_ready) begin
      e.d = fp_model(in_a, in_b, in_op);
      e.t = in_tag;
      exp_q.push_back(e);
      n_acc++;
    end
    if (out_valid && out_ready) begin
      p.d = out_data;
      p.t = out_tag;
      p.f = 3'b000;
`ifdef FP_ALU_ISSUE_FLAGS_EN
      p.f = out_flags;
`endif
      p.cyc = cyc;
      pop_log.push_back(p);
      n_pop++;
      if (exp_q.size() == 0) begin
        check("spurious_out", 64'(out_valid), 64'(0));
      end else begin
        e = exp_q.pop_front();
        check("out_data", 64'(out_data), 64'(e.d));
        check("out_tag", 64'(out_tag), 64'(e.t));
`ifdef FP_ALU_ISSUE_FLAGS_EN
        check("out_flags", 64'(out_flags), 64'(exp_flags(e.d)));
`endif
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                      input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_a = a; in_b = b; in_op = op; in_tag = t;
    while (!in_ready && n < 50) begin
      step();
      n++;
    end
    if (!in_ready) check("push_timeout", 64'(in_ready), 64'(1));
    step();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain_left", 64'(exp_q.size()), 64'(0));
    repeat (6) step();
  endtask

  task automatic rand_op(output logic [31:0] a, output logic [31:0] b, output logic [1:0] op);
    op = 2'($urandom_range(0, 3));
    a  = pool[$urandom_range(0, 7)];
    b  = (op == 2'b10) ? divs[$urandom_range(0, 3)] : pool[$urandom_range(0, 7)];
  endtask

  initial begin
    int n, idx, p0;
    logic [31:0] ra, rb;
    logic [1:0]  rop;
    logic        acc;

    pool[0] = 32'h3F800000; pool[1] = 32'h40000000; pool[2] = 32'h40400000; pool[3] = 32'h40800000;
    pool[4] = 32'h3F000000; pool[5] = 32'h40C00000; pool[6] = 32'hC0000000; pool[7] = 32'h00000000;
    divs[0] = 32'h3F800000; divs[1] = 32'h40000000; divs[2] = 32'h40800000; divs[3] = 32'h3F000000;

    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_a = '0; in_b = '0; in_op = '0; in_tag = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", 64'(in_ready), 64'(1));
    check("rst_out_valid", 64'(out_valid), 64'(0));
    check("rst_alu_a", 64'(alu_a), 64'(0));
    check("rst_alu_b", 64'(alu_b), 64'(0));
    check("rst_alu_op", 64'(alu_op), 64'(0));
    check("rst_out_data", 64'(out_data), 64'(0));
    check("rst_out_tag", 64'(out_tag), 64'(0));
`ifdef FP_ALU_ISSUE_FLAGS_EN
    check("rst_out_flags", 64'(out_flags), 64'(0));
`endif
    rst = 1'b0;
    step();

    // Single add: latency from accept to out_valid.
    out_ready = 1'b1;
    push(32'h3F800000, 32'h40000000, 2'b00, 4'd3);
    n = 0;
    while (!out_valid && n < 20) begin
      step();
      n++;
    end
    check("t1_latency", 64'(n), 64'(4));
    check("t1_data", 64'(out_data), 64'(32'h40400000));
    check("t1_tag", 64'(out_tag), 64'(3));
    drain();

    // Back-to-back mul then div, delivered on consecutive cycles.
    pop_log.delete();
    push(32'h40000000, 32'h40400000, 2'b11, 4'd1);
    push(32'h40C00000, 32'h40000000, 2'b10, 4'd2);
    drain();
    check("t2_count", 64'(pop_log.size()), 64'(2));
    if (pop_log.size() == 2) begin
      check("t2_d0", 64'(pop_log[0].d), 64'(32'h40C00000));
      check("t2_t0", 64'(pop_log[0].t), 64'(1));
      check("t2_d1", 64'(pop_log[1].d), 64'(32'h40400000));
      check("t2_t1", 64'(pop_log[1].t), 64'(2));
      check("t2_gap", 64'(pop_log[1].cyc - pop_log[0].cyc), 64'(1));
    end

    // Backpressure: 10 ops offered while the consumer stalls.
    out_ready = 1'b0;
    p0 = n_pop;
    idx = 0;
    repeat (30) begin
      if (idx < 10) begin
        in_valid = 1'b1;
        in_a = pool[idx % 8]; in_b = 32'h40000000; in_op = 2'(idx % 4); in_tag = 4'(idx);
      end else begin
        in_valid = 1'b0;
      end
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
    end
    check("t3_accepts", 64'(idx), 64'(IQ_DEPTH + RQ_DEPTH));
    check("t3_in_ready", 64'(in_ready), 64'(0));
    check("t3_out_valid", 64'(out_valid), 64'(1));
    check("t3_no_pop", 64'(n_pop - p0), 64'(0));
    out_ready = 1'b1;
    n = 0;
    while (idx < 10 && n < 50) begin
      in_valid = 1'b1;
      in_a = pool[idx % 8]; in_b = 32'h40000000; in_op = 2'(idx % 4); in_tag = 4'(idx);
      acc = in_valid && in_ready;
      step();
      if (acc) idx++;
      n++;
    end
    in_valid = 1'b0;
    drain();
    check("t3_delivered", 64'(n_pop - p0), 64'(10));

    // Reset with ops in flight and queued: nothing stale may appear afterwards.
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) push(pool[k], pool[k + 1], 2'b00, 4'(k + 8));
    rst = 1'b1;
    step();
    exp_q.delete();
    rst = 1'b0;
    check("t4_out_valid", 64'(out_valid), 64'(0));
    check("t4_in_ready", 64'(in_ready), 64'(1));
    out_ready = 1'b1;
    p0 = n_pop;
    repeat (20) step();
    check("t4_no_stale", 64'(n_pop - p0), 64'(0));
    push(32'h40800000, 32'h3F000000, 2'b11, 4'd9);
    drain();
    check("t4_recover", 64'(n_pop - p0), 64'(1));

    // NaN operand and zero result.
    pop_log.delete();
    push(32'h7FC00000, 32'h3F800000, 2'b01, 4'd5);
    push(32'h00000000, 32'h00000000, 2'b00, 4'd6);
    drain();
    check("t5_count", 64'(pop_log.size()), 64'(2));
    if (pop_log.size() == 2) begin
      check("t5_nan_data", 64'(pop_log[0].d), 64'(32'h7FC00000));
      check("t5_zero_data", 64'(pop_log[1].d), 64'(0));
`ifdef FP_ALU_ISSUE_FLAGS_EN
      check("t5_nan_flags", 64'(pop_log[0].f), 64'(3'b100));
      check("t5_zero_flags", 64'(pop_log[1].f), 64'(3'b001));
`endif
    end

    // Random traffic with random backpressure; inputs held until accepted.
    p0 = n_acc;
    in_valid = 1'b0;
    repeat (400) begin
      if (!in_valid || acc) begin
        in_valid = ($urandom_range(0, 3) != 0);
        rand_op(ra, rb, rop);
        in_a = ra; in_b = rb; in_op = rop; in_tag = 4'($urandom_range(0, 15));
      end
      out_ready = ($urandom_range(0, 9) < 6);
      acc = in_valid && in_ready;
      step();
    end
    in_valid = 1'b0;
    drain();
    check("rand_some_traffic", 64'(n_acc - p0 > 100), 64'(1));

    $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation exceeded time limit at cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
